// File: rtl/serial_word_deserializer.sv
// Serial-in/parallel-out word receiver with MSB/LSB-first assembly and a
// second-stage holding register so collection can continue while the consumer stalls.
module serial_word_deserializer #(
  parameter int N = 32,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             sdata,
  input  logic             svalid,
  input  logic             lsb_first,
  output logic             sready,
  output logic [N-1:0]     word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q;
  logic [N-1:0]     asm_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             mode_q;
  logic [N-1:0]     word_q;
  logic             word_valid_q;
  logic             overrun_q;

  logic             mode_d;
  logic [N-1:0]     asm_d;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             last_bit;
  logic             accept;
  logic             out_free;
  logic             handshake;

  // The first bit of a word picks the bit order for the whole word.
  assign mode_d    = (bit_cnt_q == '0) ? lsb_first : mode_q;
  assign asm_d     = mode_d ? {sdata, asm_q[N-1:1]} : {asm_q[N-2:0], sdata};
  assign last_bit  = (bit_cnt_q == CNT_W'(N-1));
  assign bit_cnt_d = last_bit ? '0 : bit_cnt_q + CNT_W'(1);
  assign accept    = svalid & (state_q == COLLECT);
  assign out_free  = ~word_valid_q | word_ready;
  assign handshake = word_valid_q & word_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= COLLECT;
      asm_q        <= '0;
      bit_cnt_q    <= '0;
      mode_q       <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (clr) begin
      state_q      <= COLLECT;
      asm_q        <= '0;
      bit_cnt_q    <= '0;
      mode_q       <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (handshake) word_valid_q <= 1'b0;
          if (accept) begin
            mode_q    <= mode_d;
            bit_cnt_q <= bit_cnt_d;
            asm_q     <= asm_d;
            if (last_bit) begin
              if (out_free) begin
                word_q       <= asm_d;
                word_valid_q <= 1'b1;
                asm_q        <= '0;
              end else begin
                state_q <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          // The held word moves up on handshake; word_valid stays asserted.
          if (svalid) overrun_q <= 1'b1;
          if (handshake) begin
            word_q  <= asm_q;
            asm_q   <= '0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign sready     = (state_q == COLLECT);
  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;

endmodule
